// File: rtl/inst_fetcher.sv
// inst_fetcher: instruction fetch stage in front of the decoder.
// It keeps the PC, sends one instruction-cache request at a time, and puts
// each returned word into a small queue. The decoder receives one word per
// cycle from that queue. JAL is predicted taken; every other instruction
// falls through to pc+4. A redirect flushes the queue and restarts fetch.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-low reset
//   rdy_in                  global ready; when low, all state is frozen
//   icache_req_out/addr     one-cycle fetch request and its address
//   icache_valid_in/inst_in response strobe and instruction word
//   stall_in                downstream cannot accept this cycle
//   redirect_in/pc_in       flush, then restart fetch at redirect_pc_in
//   inst_req_out            one-cycle pulse per delivered instruction
//   inst_out/pc_out         instruction word and its PC
//   pred_jump_out           fetch already followed this instruction (JAL)
//
// state      | meaning
// ST_FETCH   | may issue a request when the queue has a free slot
// ST_WAIT    | request outstanding; the response is pushed to the queue
// ST_DISCARD | request was overtaken by a redirect; the response is dropped
module inst_fetcher #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          QUEUE_DEPTH_LOG = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        icache_req_out,
  output logic [31:0] icache_addr_out,
  input  logic        icache_valid_in,
  input  logic [31:0] icache_inst_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        inst_req_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        pred_jump_out
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_LOG;

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DISCARD} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [31:0] r_q_inst [DEPTH];
  logic [31:0] r_q_pc   [DEPTH];
  logic        r_q_pred [DEPTH];

  logic [QUEUE_DEPTH_LOG-1:0] r_wr_ptr;
  logic [QUEUE_DEPTH_LOG-1:0] r_rd_ptr;
  logic [QUEUE_DEPTH_LOG:0]   r_count;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;

  logic        r_icache_req;
  logic [31:0] r_icache_addr;
  logic        r_inst_req;
  logic [31:0] r_inst;
  logic [31:0] r_pc_out;
  logic        r_pred;

  logic        w_is_jal;
  logic [31:0] w_jal_imm;
  logic [31:0] w_pred_pc;

  assign w_is_jal  = (icache_inst_in[6:0] == 7'b1101111);
  assign w_jal_imm = {{11{icache_inst_in[31]}}, icache_inst_in[31], icache_inst_in[19:12],
                      icache_inst_in[20], icache_inst_in[30:21], 1'b0};
  assign w_pred_pc = w_is_jal ? (r_pc + w_jal_imm) : (r_pc + 32'd4);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_FETCH;
    end else if (rdy_in) begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_issue    = 1'b0;
    w_push     = 1'b0;
    w_pop      = (r_count != '0) && !stall_in;
    case (r_state)
      // The count never exceeds DEPTH, so a clear MSB means a slot is free.
      ST_FETCH: begin
        if (!r_count[QUEUE_DEPTH_LOG]) begin
          w_issue    = 1'b1;
          w_state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (icache_valid_in) begin
          w_push     = 1'b1;
          w_pc_nx    = w_pred_pc;
          w_state_nx = ST_FETCH;
        end
      end
      ST_DISCARD: begin
        if (icache_valid_in) begin
          w_state_nx = ST_FETCH;
        end
      end
      default: w_state_nx = ST_FETCH;
    endcase
    // A redirect takes priority: no issue, no push, no pop. A response still in
    // flight is waited out in ST_DISCARD.
    if (redirect_in) begin
      w_issue = 1'b0;
      w_push  = 1'b0;
      w_pop   = 1'b0;
      w_pc_nx = redirect_pc_in;
      if ((r_state == ST_FETCH) || icache_valid_in) begin
        w_state_nx = ST_FETCH;
      end else begin
        w_state_nx = ST_DISCARD;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pc          <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_icache_req  <= 1'b0;
      r_icache_addr <= 32'h0;
      r_inst_req    <= 1'b0;
      r_inst        <= 32'h0;
      r_pc_out      <= 32'h0;
      r_pred        <= 1'b0;
    end else if (rdy_in) begin
      r_pc         <= w_pc_nx;
      r_icache_req <= w_issue;
      if (w_issue) begin
        r_icache_addr <= r_pc;
      end
      r_inst_req <= w_pop;
      if (w_pop) begin
        r_inst   <= r_q_inst[r_rd_ptr];
        r_pc_out <= r_q_pc[r_rd_ptr];
        r_pred   <= r_q_pred[r_rd_ptr];
      end
      if (redirect_in) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (!w_push && w_pop) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

  // Queue storage has no reset; entries are only read below the count.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_push) begin
      r_q_inst[r_wr_ptr] <= icache_inst_in;
      r_q_pc[r_wr_ptr]   <= r_pc;
      r_q_pred[r_wr_ptr] <= w_is_jal;
    end
  end

  assign icache_req_out  = r_icache_req;
  assign icache_addr_out = r_icache_addr;
  assign inst_req_out    = r_inst_req;
  assign inst_out        = r_inst;
  assign pc_out          = r_pc_out;
  assign pred_jump_out   = r_pred;

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder. It holds the PC and issues one-at-a-time fetch requests to the instruction cache. Returned words go into a small instruction queue, and the fetcher presents them to the decoder one per cycle as an `inst_req`/`inst` pulse. It applies static prediction (JAL taken, everything else fall-through) and accepts redirects from the commit/branch logic.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded at reset
QUEUE_DEPTH_LOG, 2, log2 of instruction-queue entries (default 4 entries)

Ports:
clk_in  input  1  clock, all state on rising edge
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  global ready; when low all state frozen
icache_req_out  output  1  one-cycle fetch request pulse
icache_addr_out  output  32  fetch address, valid while icache_req_out high
icache_valid_in  input  1  response strobe, exactly one per request, at least 1 cycle after it
icache_inst_in  input  32  instruction word, valid with icache_valid_in
stall_in  input  1  downstream (RS/ROB) cannot accept this cycle
redirect_in  input  1  flush and restart fetch
redirect_pc_in  input  32  new PC, valid with redirect_in
inst_req_out  output  1  instruction valid to decoder (one-cycle pulse per instruction)
inst_out  output  32  instruction word
pc_out  output  32  PC of inst_out
pred_jump_out  output  1  fetcher redirected past this instruction (JAL)

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, queue empty, state=FETCH. All outputs are 0.
- rdy_in=0: no state or output register changes. icache_valid_in is ignored, because the memory side is frozen too.
- States: FETCH, WAIT, DISCARD.
  - FETCH: if queue has a free slot (count < depth), register icache_req_out=1, icache_addr_out=pc, go to WAIT. Otherwise stay with icache_req_out=0.
  - icache_req_out is high for exactly one cycle per request.
  - WAIT: on icache_valid_in, push {icache_inst_in, pc, pred} into the queue, update pc, go to FETCH.
  - DISCARD: on icache_valid_in, drop the word and go to FETCH. pc is unchanged (already redirected).
- Prediction on the returned word:
  - opcode 7'b1101111 (JAL): next pc = pc + sign-extended J-immediate (bit 0 forced 0), pred=1.
  - All other opcodes (including branches and JALR): next pc = pc+4, pred=0.
  - Addition is 32-bit and wraps modulo 2^32.
- Dequeue: each cycle, if queue non-empty and stall_in=0, pop the head and register inst_req_out=1 with inst_out/pc_out/pred_jump_out. Otherwise inst_req_out=0 and the data outputs hold their last values.
- Latency: response at edge t is pushed at t. The earliest inst_req_out is high in the cycle after t (empty queue, no stall). Push and pop in the same cycle are allowed and keep count unchanged.
- Full queue: no new request is issued. An outstanding response always has a slot, because the request is issued only if count<depth and at most one request is outstanding.
- Queue pointers wrap modulo depth. count ranges 0..depth.
- Redirect (highest priority, when rdy_in=1):
  - Queue cleared, inst_req_out=0 at the next edge, pc=redirect_pc_in, no pop that cycle.
  - State in WAIT with no icache_valid_in this cycle: go to DISCARD.
  - State in WAIT with icache_valid_in this cycle: drop the word, go to FETCH.
  - State in FETCH or DISCARD: go to FETCH (DISCARD stays DISCARD if its response has not arrived).
  - Any icache_req_out registered this cycle is suppressed.
- Consecutive redirects: the last one wins. At most one stale response is discarded.

Test Plan:
- Reset with RESET_PC=0x0; icache returns ADDI words at 1-cycle latency, stall_in=0 -> requests to 0x0,0x4,0x8. inst_req_out pulses carry pc_out 0x0,0x4,0x8 with pred_jump_out=0.
- Word at pc 0x100 is JAL x0,+0x20 (0x0200006F) -> next icache_addr_out=0x120; that instruction comes out with pred_jump_out=1.
- stall_in=1 held for 10 cycles -> exactly 4 entries queued, then icache_req_out stays 0. Release stall_in -> 4 consecutive pulses in order, then fetch resumes.
- redirect_in with redirect_pc_in=0x200 while WAIT, response arrives 2 cycles later -> that word never appears on inst_out. The next request address is 0x200 and the queue is empty.
- redirect_in in the same cycle as icache_valid_in and a pop -> no inst_req_out next cycle, response dropped, next request at the redirect PC.
- Drop rst_in mid-WAIT asynchronously -> outputs 0 immediately. After release the first request is to RESET_PC. rdy_in=0 for 5 cycles mid-stream -> output sequence is identical, only delayed.
